// File: rtl/delay_line_ctrl_pkg.sv
// Shared definitions for the delay-line controller: state encoding,
// buffer depth derivation and the requested-delay clamp.
package delay_line_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_OUT     = 2'd2
  } state_t;

  // Number of RAM words addressed by an addr_width-bit address.
  function automatic int depth_of(input int addr_width);
    return 1 << addr_width;
  endfunction

  // The longest usable delay is DEPTH-1: a delay of DEPTH would read the
  // slot that is about to be overwritten by the same sample.
  function automatic int clamp_delay(input int delay, input int addr_width);
    int max_d;
    max_d = depth_of(addr_width) - 1;
    return (delay > max_d) ? max_d : delay;
  endfunction

endpackage

// File: rtl/delay_line_ctrl_if.sv
// Sample stream in/out plus one block-RAM port, bundled for the controller.
// The controller connects through the slave view; the surrounding effect
// top level (or a bench) uses the master view.
interface delay_line_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6
);

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;

  logic                  bram_en;
  logic                  bram_we;
  logic [ADDR_WIDTH-1:0] bram_addr;
  logic [DATA_WIDTH-1:0] bram_din;
  logic [DATA_WIDTH-1:0] bram_dout;

  modport slave (
    input  in_valid, in_data, out_ready, bram_dout,
    output in_ready, out_valid, out_data, bram_en, bram_we, bram_addr, bram_din
  );

  modport master (
    output in_valid, in_data, out_ready, bram_dout,
    input  in_ready, out_valid, out_data, bram_en, bram_we, bram_addr, bram_din
  );

endinterface

// File: rtl/delay_line_ctrl.sv
// Circular audio delay line controller. Each accepted sample reads the
// word `delay` positions back, then writes the new sample at the write
// pointer, then presents the delayed word until the consumer takes it.
module delay_line_ctrl
  import delay_line_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                clear,
  input  logic [ADDR_WIDTH:0] delay,
  delay_line_ctrl_if.slave    bus
);

  localparam int                  DEPTH    = depth_of(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] FILL_MAX = (ADDR_WIDTH + 1)'(DEPTH);

  state_t                state;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH:0]   fill;
  logic [DATA_WIDTH-1:0] s_lat;
  logic [ADDR_WIDTH:0]   d_lat;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;

  logic [ADDR_WIDTH:0]   d_eff;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  accept;

  assign d_eff   = (ADDR_WIDTH + 1)'(clamp_delay(int'(delay), ADDR_WIDTH));
  assign rd_addr = wr_ptr - d_eff[ADDR_WIDTH-1:0];

  // Ready only in IDLE and never while reset or clear is asserted, so a
  // sample presented alongside clear is refused rather than dropped.
  assign bus.in_ready = (state == ST_IDLE) && !reset && !clear;
  assign accept       = bus.in_ready && bus.in_valid;

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

  // Sequencer: IDLE issues the read, CAPTURE takes the read data and
  // writes the new sample, OUT holds the result for the consumer.
  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments keep every register updating from
    // the pre-edge values, independent of statement order.
    if (reset) begin
      state       <= ST_IDLE;
      wr_ptr      <= '0;
      fill        <= '0;
      s_lat       <= '0;
      d_lat       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (clear) begin
      // out_data is left as-is; out_valid=0 hides it.
      state       <= ST_IDLE;
      wr_ptr      <= '0;
      fill        <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            s_lat <= bus.in_data;
            d_lat <= d_eff;
            state <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (d_lat == '0) begin
            out_data_q <= s_lat;
          end else if (fill < d_lat) begin
            out_data_q <= '0;
          end else begin
            out_data_q <= bus.bram_dout;
          end
          wr_ptr      <= wr_ptr + 1'b1;
          fill        <= (fill == FILL_MAX) ? fill : fill + 1'b1;
          out_valid_q <= 1'b1;
          state       <= ST_OUT;
        end
        ST_OUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // RAM port drive: combinational so the read lands in the acceptance
  // cycle and its registered data is ready in CAPTURE.
  always_comb begin
    // NOTE: defaults first so every path assigns every output (no latches).
    bus.bram_en   = 1'b0;
    bus.bram_we   = 1'b0;
    bus.bram_addr = '0;
    bus.bram_din  = '0;
    if (!reset && !clear) begin
      if (accept) begin
        bus.bram_en   = 1'b1;
        bus.bram_addr = rd_addr;
      end else if (state == ST_CAPTURE) begin
        bus.bram_en   = 1'b1;
        bus.bram_we   = 1'b1;
        bus.bram_addr = wr_ptr;
        bus.bram_din  = s_lat;
      end
    end
  end

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Bench for delay_line_ctrl: behavioural RAM, a sample-history model and
// an expected-output queue; table vectors plus hand-written corner cases.
module tb_delay_line_ctrl;

  localparam int DW = 16;
  localparam int AW = 6;
  localparam int DEPTH = 64;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          clear = 1'b0;
  logic [AW:0]   delay = '0;

  delay_line_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  delay_line_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock (clock),
    .reset (reset),
    .clear (clear),
    .delay (delay),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Single-port view of the block RAM, registered read. Filled with junk
  // so unwritten slots are distinguishable from the masked zero.
  logic [DW-1:0] mem [DEPTH];
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(16'hDEA0 + i);
  end
  always @(posedge clock) begin
    if (bus.bram_en) begin
      if (bus.bram_we) mem[bus.bram_addr] <= bus.bram_din;
      else             bus.bram_dout      <= mem[bus.bram_addr];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] hist [$];
  int            m_count = 0;

  typedef struct {
    logic [AW:0]   dly;
    logic [DW-1:0] din;
    logic [DW-1:0] exp_out;
    logic [AW-1:0] exp_raddr;
  } vec_t;
  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    hist.delete();
    m_count = 0;
  endtask

  // One full transaction starting at a negedge; stall = cycles out_ready
  // is held low once the output appears.
  task automatic send(input logic [AW:0] dly, input logic [DW-1:0] din,
                      input logic [DW-1:0] exp_out, input logic [AW-1:0] exp_raddr,
                      input int stall);
    logic [AW-1:0] waddr;
    int waited;
    waddr  = AW'(m_count % DEPTH);
    waited = 0;
    while (bus.in_ready !== 1'b1 && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    if (bus.in_ready !== 1'b1) begin
      check("accept_timeout", 32'(bus.in_ready), 1);
      return;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = din;
    delay        = dly;
    #1;
    check("rd_en", 32'(bus.bram_en), 1);
    check("rd_we", 32'(bus.bram_we), 0);
    check("rd_addr", 32'(bus.bram_addr), 32'(exp_raddr));
    exp_q.push_back(exp_out);
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    bus.in_data  = DW'($urandom);
    delay        = (AW + 1)'($urandom);
    if (stall > 0) bus.out_ready = 1'b0;
    @(negedge clock);
    check("cap_out_valid", 32'(bus.out_valid), 0);
    check("cap_in_ready", 32'(bus.in_ready), 0);
    check("wr_en_we", 32'({bus.bram_en, bus.bram_we}), 3);
    check("wr_addr", 32'(bus.bram_addr), 32'(waddr));
    check("wr_din", 32'(bus.bram_din), 32'(din));
    @(negedge clock);
    check("out_valid", 32'(bus.out_valid), 1);
    check("out_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
    for (int i = 0; i < stall; i++) begin
      @(negedge clock);
      check("hold_valid", 32'(bus.out_valid), 1);
      check("hold_data", 32'(bus.out_data), 32'(exp_out));
      check("hold_in_ready", 32'(bus.in_ready), 0);
      check("hold_bram_en", 32'(bus.bram_en), 0);
    end
    bus.out_ready = 1'b1;
    @(negedge clock);
    check("out_drop", 32'(bus.out_valid), 0);
    hist.push_back(din);
    m_count++;
  endtask

  task automatic send_model(input logic [AW:0] dly, input logic [DW-1:0] din, input int stall);
    int deff;
    logic [DW-1:0] e;
    deff = (int'(dly) > DEPTH - 1) ? DEPTH - 1 : int'(dly);
    if (deff == 0)          e = din;
    else if (m_count < deff) e = '0;
    else                     e = hist[m_count - deff];
    send(dly, din, e, AW'((m_count - deff + DEPTH) % DEPTH), stall);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    model_clear();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{dly: 7'd3, din: 16'd1, exp_out: 16'd0, exp_raddr: 6'd61};
    vecs[1] = '{dly: 7'd3, din: 16'd2, exp_out: 16'd0, exp_raddr: 6'd62};
    vecs[2] = '{dly: 7'd3, din: 16'd3, exp_out: 16'd0, exp_raddr: 6'd63};
    vecs[3] = '{dly: 7'd3, din: 16'd4, exp_out: 16'd1, exp_raddr: 6'd0};
    vecs[4] = '{dly: 7'd3, din: 16'd5, exp_out: 16'd2, exp_raddr: 6'd1};
    vecs[5] = '{dly: 7'd3, din: 16'd6, exp_out: 16'd3, exp_raddr: 6'd2};

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;

    // Reset values
    repeat (3) @(negedge clock);
    check("rst_in_ready", 32'(bus.in_ready), 0);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_data", 32'(bus.out_data), 0);
    check("rst_bram_en", 32'(bus.bram_en), 0);
    check("rst_bram_we", 32'(bus.bram_we), 0);
    check("rst_bram_addr", 32'(bus.bram_addr), 0);
    check("rst_bram_din", 32'(bus.bram_din), 0);
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_in_ready", 32'(bus.in_ready), 1);

    // Passthrough
    send_model(7'd0, 16'h0011, 0);
    send_model(7'd0, 16'h0022, 0);

    // Table: delay=3 from an empty line
    do_clear();
    for (int i = 0; i < 6; i++)
      send(vecs[i].dly, vecs[i].din, vecs[i].exp_out, vecs[i].exp_raddr, 0);

    // Oversized delay clamps to 63
    do_clear();
    for (int n = 1; n <= 70; n++) send_model(7'd100, DW'(n), 0);

    // Consumer stall
    send_model(7'd5, 16'hBEEF, 10);

    // Pointer wrap and fill saturation
    do_clear();
    for (int n = 0; n < 69; n++) send_model(7'd2, DW'(16'h1000 + n), 0);

    // clear during CAPTURE with a new sample offered
    bus.in_valid = 1'b1;
    bus.in_data  = 16'hAAAA;
    delay        = 7'd2;
    @(posedge clock);
    #1;
    bus.in_data  = 16'hBBBB;
    @(negedge clock);
    clear = 1'b1;
    #1;
    check("clr_cap_in_ready", 32'(bus.in_ready), 0);
    @(negedge clock);
    clear        = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check("clr_cap_out_valid", 32'(bus.out_valid), 0);
    check("clr_cap_idle", 32'(bus.in_ready), 1);
    model_clear();
    send_model(7'd2, 16'h0101, 0);
    send_model(7'd2, 16'h0202, 0);
    send_model(7'd2, 16'h0303, 0);
    send_model(7'd2, 16'h0404, 0);

    // clear wins over in_valid in IDLE
    clear        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'hCCCC;
    #1;
    check("clr_idle_in_ready", 32'(bus.in_ready), 0);
    check("clr_idle_bram_en", 32'(bus.bram_en), 0);
    @(negedge clock);
    clear        = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clock);
    check("clr_idle_out_valid", 32'(bus.out_valid), 0);
    check("clr_idle_not_accepted", 32'(bus.in_ready), 1);
    model_clear();
    send_model(7'd1, 16'h0707, 0);

    // reset while the output is being held
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'h5A5A;
    delay         = 7'd0;
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("mid_out_valid", 32'(bus.out_valid), 1);
    check("mid_out_data", 32'(bus.out_data), 32'h5A5A);
    reset = 1'b1;
    @(negedge clock);
    check("mid_rst_out_valid", 32'(bus.out_valid), 0);
    check("mid_rst_out_data", 32'(bus.out_data), 0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 0);
    reset = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    check("mid_rst_release", 32'(bus.in_ready), 1);
    model_clear();
    send_model(7'd1, 16'h0909, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
